bit_reverse_buffer: RTL and testbench
=====================================

BIT_REVERSE_BUFFER -- requirements
Module: bit_reverse_buffer

Interface
REQ-001 Parameter: WIDTH, 16, bit width of each real/imaginary sample.
REQ-002 Parameter: LOG2N, 5, log2 of frame length; N = 2^LOG2N = 32 points.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: valid_i  input  1  data_in_r/data_in_i carry one FFT output sample this cycle.
REQ-006 Port: data_in_r  input  WIDTH (signed)  real part of the input sample, in bit-reversed order.
REQ-007 Port: data_in_i  input  WIDTH (signed)  imaginary part of the input sample.
REQ-008 Port: valid_o  output  1  registered; data_out_r/data_out_i hold a natural-order sample.
REQ-009 Port: data_out_r  output  WIDTH (signed)  registered real part of the output sample.
REQ-010 Port: data_out_i  output  WIDTH (signed)  registered imaginary part of the output sample.
REQ-011 Port: busy  output  1  registered; high while a partial frame is held or a readout is in progress.

Function
REQ-012 The block SHALL reorder the FFT pipeline's bit-reversed output stream into natural order, one complex sample per cycle.
REQ-013 Storage SHALL be two banks (ping-pong), each N x 2*WIDTH; one bank is written while the other is read.
REQ-014 Write side: counter wcnt (LOG2N bits) and bank select wbank; each cycle with valid_i=1 writes the sample to wbank at address bitrev(wcnt), then wcnt increments.
REQ-015 valid_i=0 cycles SHALL hold wcnt and perform no write; gaps of any length are legal mid-frame.
REQ-016 When the write with wcnt=N-1 occurs, wcnt SHALL wrap to 0, wbank SHALL toggle, and a read of the just-filled bank SHALL be requested.
REQ-017 Read-side FSM states: IDLE (no readout), READ (rcnt 0..N-1 from rbank).
REQ-018 IDLE->READ on a read request; rbank <= filled bank, rcnt <= 0.
REQ-019 In READ, each cycle the block SHALL register bank[rbank][rcnt] to data_out, drive valid_o=1, and increment rcnt.
REQ-020 Latency: the sample at natural index 0 SHALL appear on the first rising edge after the edge that captured the N-th input; the remaining N-1 follow on consecutive cycles with no gaps.
REQ-021 READ->IDLE after rcnt=N-1 is output, unless a new read request is pending, in which case READ SHALL continue directly on the other bank with no bubble cycle.
REQ-022 Back-to-back frames with continuous valid_i SHALL produce a continuous valid_o stream; no overflow condition exists since a bank fills in at least N cycles.
REQ-023 A read request arriving on the same edge as the final read of the previous bank SHALL be honoured (pending flag), not dropped.
REQ-024 When valid_o=0, data_out_r and data_out_i SHALL be 0.
REQ-025 Data SHALL pass unmodified: no scaling, rounding or sign change.
REQ-026 busy SHALL be 1 when wcnt != 0, the FSM is in READ, or a read request is pending; otherwise 0.

Reset
REQ-027 rst=0 SHALL immediately force valid_o=0, data_out_r=0, data_out_i=0, busy=0, FSM=IDLE, wcnt=0, wbank=0, pending=0.
REQ-028 Bank memory contents are not reset; a partial frame or readout in progress at reset SHALL be discarded and never output.
REQ-029 After rst returns high, the next accepted valid_i sample SHALL be treated as bit-reversed index 0 of a new frame.

Verification
REQ-030 Reset: assert rst mid-stream -> valid_o, data_out_r, data_out_i, busy all 0 asynchronously, before the next clock edge.
REQ-031 Single frame: 32 continuous samples, sample k has data_in_r = 100+bitrev(k), data_in_i = -bitrev(k) -> starting the edge after the 32nd input, 32 contiguous valid_o cycles with data_out_r = 100..131 and data_out_i = 0..-31.
REQ-032 Back-to-back: two frames, 64 continuous valid_i cycles, second frame offset by +1000 -> 64 contiguous valid_o cycles, natural order, no bubble between frames.
REQ-033 Gapped input: valid_i high every other cycle for one frame -> output starts one edge after the 32nd accepted sample and is 32 contiguous correct samples.
REQ-034 Reset mid-frame: 10 samples, rst pulse, then a full frame -> exactly 32 outputs, all from the post-reset frame.
REQ-035 Reset during readout at output index 5 -> valid_o drops at once and no further outputs occur; a following full frame is output correctly.

Source files
------------

// File: rtl/bit_reverse_buffer.sv
// Ping-pong reorder buffer: bit-reversed FFT output stream in,
// natural-order stream out, one complex sample per cycle.
module bit_reverse_buffer #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic                    busy
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [2][N];

  state_t           state_q, state_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic             pend_q, pend_d;
  logic             vld_d;
  logic [WIDTH-1:0] dr_d, di_d;
  logic             busy_d;
  logic             req;
  logic [2*WIDTH-1:0] rd;

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      mem[wbank_q][bitrev(wcnt_q)] <= {data_in_r, data_in_i};
    end
  end

  assign req = valid_i && (wcnt_q == LAST);
  assign rd  = mem[rbank_q][rcnt_q];

  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    dr_d    = '0;
    di_d    = '0;

    if (valid_i) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    if (req) begin
      wbank_d = ~wbank_q;
    end

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = READ;
          rbank_d = wbank_q;
          rcnt_d  = '0;
        end
      end
      READ: begin
        vld_d  = 1'b1;
        dr_d   = rd[2*WIDTH-1:WIDTH];
        di_d   = rd[WIDTH-1:0];
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LAST) begin
          // Chain straight onto the other bank if it is full.
          if (pend_q) begin
            rbank_d = ~rbank_q;
            rcnt_d  = '0;
            pend_d  = req;
          end else if (req) begin
            rbank_d = wbank_q;
            rcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (req) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (wcnt_d != '0) || (state_d == READ) || pend_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      rcnt_q     <= '0;
      rbank_q    <= 1'b0;
      pend_q     <= 1'b0;
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wbank_q    <= wbank_d;
      rcnt_q     <= rcnt_d;
      rbank_q    <= rbank_d;
      pend_q     <= pend_d;
      valid_o    <= vld_d;
      data_out_r <= dr_d;
      data_out_i <= di_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bit_reverse_buffer.sv
// Bench for bit_reverse_buffer: directed frames plus random data,
// checked against a frame-level reorder model.
module tb_bit_reverse_buffer;

  localparam int W = 16;
  localparam int N = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] i;
  } smp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                valid_i;
  logic signed [W-1:0] data_in_r;
  logic signed [W-1:0] data_in_i;
  logic                valid_o;
  logic signed [W-1:0] data_out_r;
  logic signed [W-1:0] data_out_i;
  logic                busy;

  int   errors = 0;
  int   checks = 0;
  int   nout   = 0;
  int   mw     = 0;
  smp_t frame [N];
  smp_t exp_q [$];

  bit_reverse_buffer #(.WIDTH(W), .LOG2N(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < 5; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, W'(valid_o), W'(0));
    chk({tag, "_dr"}, data_out_r, W'(0));
    chk({tag, "_di"}, data_out_i, W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
  endtask

  task automatic cycle(input logic v,
                       input logic [W-1:0] r,
                       input logic [W-1:0] i);
    smp_t e;
    valid_i   = v;
    data_in_r = r;
    data_in_i = i;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("valid_o", W'(valid_o), W'(1));
      chk("data_out_r", data_out_r, e.r);
      chk("data_out_i", data_out_i, e.i);
      nout++;
    end else begin
      chk("valid_o_idle", W'(valid_o), W'(0));
      chk("dr_idle", data_out_r, W'(0));
      chk("di_idle", data_out_i, W'(0));
    end
    if (v) begin
      frame[mw] = '{r: r, i: i};
      mw++;
      if (mw == N) begin
        for (int n = 0; n < N; n++) begin
          exp_q.push_back(frame[brev(n)]);
        end
        mw = 0;
      end
    end
    chk("busy", W'(busy), W'((mw != 0) || (exp_q.size() != 0)));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, W'(0), W'(0));
    end
  endtask

  task automatic rand_frame(input int gap_pct);
    for (int k = 0; k < N; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        cycle(1'b0, W'($urandom), W'($urandom));
      end
      cycle(1'b1, W'($urandom), W'($urandom));
    end
  endtask

  task automatic pulse_reset(input string tag);
    valid_i = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk_quiet({tag, "_async"});
    exp_q.delete();
    mw = 0;
    @(posedge clk);
    #1;
    chk_quiet({tag, "_held"});
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    valid_i   = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    #2;
    chk_quiet("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single frame, directed values
    for (int k = 0; k < N; k++) begin
      cycle(1'b1, W'(100 + brev(k)), W'(-brev(k)));
    end
    idle(N + 4);

    // back-to-back, second frame offset by +1000
    for (int k = 0; k < 2 * N; k++) begin
      cycle(1'b1, W'(100 + brev(k % N) + (k / N) * 1000),
            W'(-brev(k % N) - (k / N) * 1000));
    end
    idle(N + 4);

    // every other cycle valid
    for (int k = 0; k < N; k++) begin
      cycle(1'b1, W'($urandom), W'($urandom));
      cycle(1'b0, W'($urandom), W'($urandom));
    end
    idle(N + 4);

    // reset mid-frame, then one full frame
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, W'(7000 + k), W'(-7000 - k));
    end
    pulse_reset("rst_wr");
    nout = 0;
    rand_frame(0);
    idle(N + 4);
    chk("rst_wr_count", W'(nout), W'(N));

    // reset while output index 5 is on the port
    rand_frame(0);
    idle(6);
    pulse_reset("rst_rd");
    idle(N + 4);
    rand_frame(0);
    idle(N + 4);

    // random gaps across several chained frames
    for (int f = 0; f < 4; f++) begin
      rand_frame(f * 15);
    end
    idle(2 * N + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
